// File: rtl/sphere_scan_ctrl_pkg.sv
// Shared types and constants for the per-pixel sphere scan controller.
// The state codes are plain localparams so older blocks can match them bit-for-bit.
package sphere_scan_ctrl_pkg;

  typedef logic [63:0] fixed_real;
  typedef logic [1:0]  sphere_idx_t;

  localparam fixed_real DIST_MAX = '1;

  typedef logic [1:0] scan_state_t;

  localparam scan_state_t IDLE  = 2'd0;
  localparam scan_state_t ISSUE = 2'd1;
  localparam scan_state_t WAIT  = 2'd2;
  localparam scan_state_t DONE  = 2'd3;

endpackage

// File: rtl/sphere_scan_ctrl_nearest_hit_tracker.sv
// Keeps the nearest hit seen so far for the pixel being scanned.
// The next-state values are exported so the FSM can latch a result that includes the final sample.
module nearest_hit_tracker #(
  parameter int IDX_W  = 2,
  parameter int DIST_W = 64
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              clear_i,
  input  logic              update_i,
  input  logic              hit_i,
  input  logic [DIST_W-1:0] dist_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic              best_hit_o,
  output logic [IDX_W-1:0]  best_idx_o,
  output logic              next_hit_o,
  output logic [IDX_W-1:0]  next_idx_o,
  output logic [DIST_W-1:0] next_dist_o
);

  logic              best_hit_q, best_hit_d;
  logic [DIST_W-1:0] best_dist_q, best_dist_d;
  logic [IDX_W-1:0]  best_idx_q, best_idx_d;

  // Strict compare keeps the lower index on ties, and an all-ones distance can never beat the all-ones seed.
  always_comb begin
    best_hit_d  = best_hit_q;
    best_dist_d = best_dist_q;
    best_idx_d  = best_idx_q;
    if (clear_i) begin
      best_hit_d  = 1'b0;
      best_dist_d = '1;
      best_idx_d  = '0;
    end else if (update_i && hit_i && (dist_i < best_dist_q)) begin
      best_hit_d  = 1'b1;
      best_dist_d = dist_i;
      best_idx_d  = idx_i;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      best_hit_q  <= 1'b0;
      best_dist_q <= '1;
      best_idx_q  <= '0;
    end else begin
      best_hit_q  <= best_hit_d;
      best_dist_q <= best_dist_d;
      best_idx_q  <= best_idx_d;
    end
  end

  assign best_hit_o  = best_hit_q;
  assign best_idx_o  = best_idx_q;
  assign next_hit_o  = best_hit_d;
  assign next_idx_o  = best_idx_d;
  assign next_dist_o = best_dist_d;

endmodule

// File: rtl/sphere_scan_ctrl.sv
// Walks the sphere register read port over every sphere for one ray, keeps the nearest hit,
// and hands one result per pixel downstream; also pulses Hit/Hit_index back to the sphere register.
module sphere_scan_ctrl
  import sphere_scan_ctrl_pkg::*;
#(
  parameter int N_SPHERES = 4,
  parameter int IDX_W     = 2,
  parameter int DIST_W    = 64
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Pix_valid,
  output logic              Pix_ready,
  output logic [IDX_W-1:0]  Read_index,
  input  logic              Isect_valid,
  input  logic              Isect_hit,
  input  logic [DIST_W-1:0] Isect_dist,
  output logic              Res_valid,
  input  logic              Res_ready,
  output logic              Res_hit,
  output logic [IDX_W-1:0]  Res_index,
  output logic [DIST_W-1:0] Res_dist,
  output logic              Hit,
  output logic [IDX_W-1:0]  Hit_index
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SPHERES - 1);

  scan_state_t       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              res_valid_q, res_valid_d;
  logic              res_hit_q, res_hit_d;
  logic [IDX_W-1:0]  res_idx_q, res_idx_d;
  logic [DIST_W-1:0] res_dist_q, res_dist_d;
  logic              hit_q, hit_d;
  logic [IDX_W-1:0]  hit_idx_q, hit_idx_d;

  logic              trk_clear, trk_update;
  logic              best_hit, next_hit;
  logic [IDX_W-1:0]  best_idx, next_idx;
  logic [DIST_W-1:0] next_dist;

  nearest_hit_tracker #(
    .IDX_W  (IDX_W),
    .DIST_W (DIST_W)
  ) u_tracker (
    .Clk         (Clk),
    .Reset       (Reset),
    .clear_i     (trk_clear),
    .update_i    (trk_update),
    .hit_i       (Isect_hit),
    .dist_i      (Isect_dist),
    .idx_i       (idx_q),
    .best_hit_o  (best_hit),
    .best_idx_o  (best_idx),
    .next_hit_o  (next_hit),
    .next_idx_o  (next_idx),
    .next_dist_o (next_dist)
  );

  // ISSUE lasts one cycle to cover the register file's read latency; the result is latched on the last sample.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    res_valid_d = res_valid_q;
    res_hit_d   = res_hit_q;
    res_idx_d   = res_idx_q;
    res_dist_d  = res_dist_q;
    hit_d       = 1'b0;
    hit_idx_d   = hit_idx_q;
    trk_clear   = 1'b0;
    trk_update  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Pix_valid) begin
          state_d   = ISSUE;
          idx_d     = '0;
          trk_clear = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (Isect_valid) begin
          trk_update = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d     = DONE;
            res_valid_d = 1'b1;
            res_hit_d   = next_hit;
            res_idx_d   = next_idx;
            res_dist_d  = next_dist;
          end else begin
            state_d = ISSUE;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        if (Res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
          hit_d       = best_hit;
          hit_idx_d   = best_idx;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
      res_idx_q   <= '0;
      res_dist_q  <= '1;
      hit_q       <= 1'b0;
      hit_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      res_valid_q <= res_valid_d;
      res_hit_q   <= res_hit_d;
      res_idx_q   <= res_idx_d;
      res_dist_q  <= res_dist_d;
      hit_q       <= hit_d;
      hit_idx_q   <= hit_idx_d;
    end
  end

  assign Pix_ready  = (state_q == IDLE);
  assign Read_index = idx_q;
  assign Res_valid  = res_valid_q;
  assign Res_hit    = res_hit_q;
  assign Res_index  = res_idx_q;
  assign Res_dist   = res_dist_q;
  assign Hit        = hit_q;
  assign Hit_index  = hit_idx_q;

endmodule

// File: tb/tb_sphere_scan_ctrl.sv
// Self-checking bench for sphere_scan_ctrl: an open-loop responder driven from a per-pixel
// timeline, a nearest-hit reference, and one negedge compare process.
module tb_sphere_scan_ctrl;

  localparam int N      = 4;
  localparam int IDX_W  = 2;
  localparam int DIST_W = 64;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic              Clk;
  logic              Reset;
  logic              Pix_valid;
  logic              Pix_ready;
  logic [IDX_W-1:0]  Read_index;
  logic              Isect_valid;
  logic              Isect_hit;
  logic [DIST_W-1:0] Isect_dist;
  logic              Res_valid;
  logic              Res_ready;
  logic              Res_hit;
  logic [IDX_W-1:0]  Res_index;
  logic [DIST_W-1:0] Res_dist;
  logic              Hit;
  logic [IDX_W-1:0]  Hit_index;

  sphere_scan_ctrl #(
    .N_SPHERES (N),
    .IDX_W     (IDX_W),
    .DIST_W    (DIST_W)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Pix_valid   (Pix_valid),
    .Pix_ready   (Pix_ready),
    .Read_index  (Read_index),
    .Isect_valid (Isect_valid),
    .Isect_hit   (Isect_hit),
    .Isect_dist  (Isect_dist),
    .Res_valid   (Res_valid),
    .Res_ready   (Res_ready),
    .Res_hit     (Res_hit),
    .Res_index   (Res_index),
    .Res_dist    (Res_dist),
    .Hit         (Hit),
    .Hit_index   (Hit_index)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int checks   = 0;
  int failures = 0;

  bit          chkEn = 1'b0;
  bit          expPixReady, expResValid, expHit, expResHit;
  int          expRead;
  logic [1:0]  expHitIdx, expResIdx;
  logic [63:0] expResDist;

  int          lat   [N];
  bit          hitv  [N];
  logic [63:0] distv [N];

  bit          pendingHit;
  logic [1:0]  pendingIdx;
  int          lastIdx;

  int          firstValid;
  bit          obsHit;
  logic [1:0]  obsIdx;
  logic [63:0] obsDist;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: nearest finite hit, lowest index wins on equal distance.
  function automatic void nearest(output bit h, output logic [1:0] i, output logic [63:0] d);
    h = 1'b0;
    i = 2'd0;
    d = ONES;
    for (int k = 0; k < N; k++) begin
      if (hitv[k] && distv[k] != ONES && (!h || distv[k] < d)) begin
        h = 1'b1;
        i = 2'(k);
        d = distv[k];
      end
    end
  endfunction

  always @(negedge Clk) begin
    if (chkEn) begin
      checkOutput("Pix_ready", 64'(Pix_ready), 64'(expPixReady));
      checkOutput("Res_valid", 64'(Res_valid), 64'(expResValid));
      checkOutput("Read_index", 64'(Read_index), 64'(expRead));
      checkOutput("Hit", 64'(Hit), 64'(expHit));
      if (expHit) checkOutput("Hit_index", 64'(Hit_index), 64'(expHitIdx));
      if (expResValid) begin
        checkOutput("Res_hit", 64'(Res_hit), 64'(expResHit));
        checkOutput("Res_index", 64'(Res_index), 64'(expResIdx));
        checkOutput("Res_dist", Res_dist, expResDist);
      end
    end
  end

  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic idleCycle(input bit pv);
    cycle();
    Pix_valid   = pv;
    Res_ready   = 1'($urandom_range(0, 1));
    Isect_valid = 1'($urandom_range(0, 1));
    Isect_hit   = 1'b1;
    Isect_dist  = 64'd0;
    expPixReady = 1'b1;
    expResValid = 1'b0;
    expHit      = pendingHit;
    expHitIdx   = pendingIdx;
    expRead     = lastIdx;
    pendingHit  = 1'b0;
    chkEn       = 1'b1;
  endtask

  // One pixel: sphere k is issued at offset off[k] after acceptance and answered lat[k] WAIT cycles later.
  task automatic applyStimulus(input int stall, input int gap, input bit spur, input bit holdPix,
                               input int abortAt);
    int off [N];
    int doneAt;
    int k;
    bit eh;
    logic [1:0] ei;
    logic [63:0] ed;
    doneAt = 1;
    for (int j = 0; j < N; j++) begin
      off[j] = doneAt;
      doneAt += lat[j] + 2;
    end
    nearest(eh, ei, ed);
    firstValid = -1;
    for (int g = 0; g < gap; g++) idleCycle(1'b0);
    idleCycle(1'b1);
    for (int c = 1; c <= doneAt + stall; c++) begin
      cycle();
      if (c == abortAt) begin
        chkEn       = 1'b0;
        Isect_valid = 1'b0;
        Pix_valid   = 1'b0;
        return;
      end
      Pix_valid = holdPix ? 1'b1 : 1'($urandom_range(0, 1));
      if (Res_valid && firstValid < 0) firstValid = c;
      if (c < doneAt) begin
        k = 0;
        for (int j = 0; j < N; j++) if (c >= off[j]) k = j;
        expPixReady = 1'b0;
        expResValid = 1'b0;
        expHit      = 1'b0;
        expRead     = k;
        Res_ready   = 1'($urandom_range(0, 1));
        if (c == off[k]) begin
          Isect_valid = spur;
          Isect_hit   = 1'b1;
          Isect_dist  = 64'd0;
        end else begin
          Isect_valid = ((c - off[k] - 1) == lat[k]);
          Isect_hit   = hitv[k];
          Isect_dist  = Isect_valid ? distv[k] : {$urandom, $urandom};
        end
      end else begin
        if (c == doneAt) begin
          obsHit  = Res_hit;
          obsIdx  = Res_index;
          obsDist = Res_dist;
        end
        expPixReady = 1'b0;
        expResValid = 1'b1;
        expHit      = 1'b0;
        expRead     = N - 1;
        expResHit   = eh;
        expResIdx   = ei;
        expResDist  = ed;
        Res_ready   = (c == doneAt + stall);
        Isect_valid = spur;
        Isect_hit   = 1'b1;
        Isect_dist  = 64'd0;
      end
    end
    pendingHit = eh;
    pendingIdx = ei;
    lastIdx    = N - 1;
  endtask

  task automatic setAll(input int l, input bit h);
    for (int j = 0; j < N; j++) begin
      lat[j]  = l;
      hitv[j] = h;
      distv[j] = {$urandom, $urandom};
    end
  endtask

  function automatic logic [63:0] pickDist();
    case ($urandom_range(0, 3))
      0:       return ONES;
      1:       return 64'($urandom_range(1, 4));
      2:       return {$urandom, $urandom};
      default: return 64'h0000_0005_0000_0000;
    endcase
  endfunction

  initial begin
    Reset       = 1'b1;
    Pix_valid   = 1'b0;
    Isect_valid = 1'b0;
    Isect_hit   = 1'b0;
    Isect_dist  = 64'd0;
    Res_ready   = 1'b0;
    pendingHit  = 1'b0;
    pendingIdx  = 2'd0;
    lastIdx     = 0;
    #2;
    checkOutput("rst_Pix_ready", 64'(Pix_ready), 64'd1);
    checkOutput("rst_Res_valid", 64'(Res_valid), 64'd0);
    checkOutput("rst_Hit", 64'(Hit), 64'd0);
    checkOutput("rst_Read_index", 64'(Read_index), 64'd0);
    checkOutput("rst_Res_dist", Res_dist, ONES);
    #10;
    Reset = 1'b0;

    // No hits anywhere, zero-latency responder.
    setAll(0, 1'b0);
    applyStimulus(0, 1, 1'b0, 1'b0, -1);
    checkOutput("p1_latency", 64'(firstValid), 64'd9);
    checkOutput("p1_Res_hit", 64'(obsHit), 64'd0);
    checkOutput("p1_Res_dist", obsDist, ONES);
    idleCycle(1'b0);
    checkOutput("p1_no_Hit", 64'(Hit), 64'd0);

    // Tie between spheres 1 and 3.
    setAll(0, 1'b1);
    distv[0] = 64'h0000_0A00_0000_0000;
    distv[1] = 64'h0000_0500_0000_0000;
    distv[2] = 64'h0000_0800_0000_0000;
    distv[3] = 64'h0000_0500_0000_0000;
    applyStimulus(0, 0, 1'b0, 1'b0, -1);
    checkOutput("p2_Res_index", 64'(obsIdx), 64'd1);
    checkOutput("p2_Res_dist", obsDist, 64'h0000_0500_0000_0000);
    idleCycle(1'b0);
    checkOutput("p2_Hit", 64'(Hit), 64'd1);
    checkOutput("p2_Hit_index", 64'(Hit_index), 64'd1);

    // Only the last sphere hits.
    setAll(0, 1'b0);
    hitv[3]  = 1'b1;
    distv[3] = 64'd1;
    applyStimulus(1, 0, 1'b1, 1'b0, -1);
    checkOutput("p3_Res_hit", 64'(obsHit), 64'd1);
    checkOutput("p3_Res_index", 64'(obsIdx), 64'd3);
    checkOutput("p3_Res_dist", obsDist, 64'd1);

    // Slow responder with spurious pulses during ISSUE.
    setAll(4, 1'b1);
    applyStimulus(0, 1, 1'b1, 1'b0, -1);
    checkOutput("p4_latency", 64'(firstValid), 64'd25);

    // Long stall in DONE, then a back-to-back pixel.
    setAll(0, 1'b1);
    applyStimulus(10, 0, 1'b0, 1'b1, -1);
    setAll(1, 1'b1);
    applyStimulus(0, 0, 1'b0, 1'b1, -1);

    // All-ones hits never count.
    setAll(0, 1'b1);
    for (int j = 0; j < N; j++) distv[j] = ONES;
    applyStimulus(0, 0, 1'b0, 1'b0, -1);
    checkOutput("p7_Res_hit", 64'(obsHit), 64'd0);
    checkOutput("p7_Res_index", 64'(obsIdx), 64'd0);

    // Abort in WAIT on index 2.
    setAll(0, 1'b1);
    lat[2] = 20;
    applyStimulus(0, 0, 1'b0, 1'b0, 8);
    #2;
    Reset = 1'b1;
    #1;
    checkOutput("abort_Pix_ready", 64'(Pix_ready), 64'd1);
    checkOutput("abort_Res_valid", 64'(Res_valid), 64'd0);
    checkOutput("abort_Res_hit", 64'(Res_hit), 64'd0);
    checkOutput("abort_Res_index", 64'(Res_index), 64'd0);
    checkOutput("abort_Res_dist", Res_dist, ONES);
    checkOutput("abort_Hit", 64'(Hit), 64'd0);
    checkOutput("abort_Hit_index", 64'(Hit_index), 64'd0);
    checkOutput("abort_Read_index", 64'(Read_index), 64'd0);
    @(posedge Clk);
    @(posedge Clk);
    #3;
    Reset      = 1'b0;
    pendingHit = 1'b0;
    lastIdx    = 0;
    setAll(0, 1'b1);
    distv[2] = 64'd7;
    applyStimulus(0, 2, 1'b0, 1'b0, -1);

    // Randomised pixels.
    for (int p = 0; p < 40; p++) begin
      for (int j = 0; j < N; j++) begin
        lat[j]   = $urandom_range(0, 3);
        hitv[j]  = 1'($urandom_range(0, 1));
        distv[j] = pickDist();
      end
      applyStimulus($urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), -1);
    end
    idleCycle(1'b0);
    idleCycle(1'b0);
    @(negedge Clk);
    chkEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sphere_scan_ctrl.md
Name: sphere_scan_ctrl

Overview:
Per-pixel scheduler that walks the sphere register file's read port across all spheres for one ray. For each sphere it issues the sphere index, waits for the downstream intersection unit's result, and keeps the nearest hit. It then returns one result per pixel to the pixel pipeline over a valid/ready handshake. It also drives the sphere register's Hit / Hit_index inputs with the winning sphere. It sits between the pixel/ray generator, the sphere register file (registered read, 1-cycle latency) and the ray-sphere intersection unit.

Parameters:
N_SPHERES, 4, number of spheres scanned per pixel (≥2).
IDX_W, 2, width of the sphere index; must satisfy 2**IDX_W ≥ N_SPHERES.
DIST_W, 64, width of the distance; unsigned fixed point, 32 integer bits and 32 fraction bits.

Ports:
Clk  in  1  system clock.
Reset  in  1  asynchronous, active-high reset.
Pix_valid  in  1  a new ray/pixel is ready to be scanned.
Pix_ready  out  1  controller is idle and accepts a pixel.
Read_index  out  IDX_W  sphere index presented to the sphere register read port.
Isect_valid  in  1  intersection result for the current index is valid (single-cycle pulse).
Isect_hit  in  1  ray hits the current sphere.
Isect_dist  in  DIST_W  distance to the hit point; ignored when Isect_hit=0.
Res_valid  out  1  per-pixel result available.
Res_ready  in  1  consumer accepts the result.
Res_hit  out  1  at least one sphere was hit.
Res_index  out  IDX_W  index of the nearest hit sphere; 0 when Res_hit=0.
Res_dist  out  DIST_W  nearest hit distance; all-ones when Res_hit=0.
Hit  out  1  one-cycle pulse to the sphere register on result handoff when Res_hit=1.
Hit_index  out  IDX_W  equals Res_index; valid while Hit=1.

Behaviour:
- Reset (async) values:
  - state=IDLE, Read_index=0.
  - Pix_ready=1, Res_valid=0, Res_hit=0, Res_index=0, Res_dist=all-ones.
  - Hit=0, Hit_index=0.
- Reset mid-scan aborts the scan; no result or Hit is produced for the aborted pixel.
- Read_index, all Res_* outputs and Hit / Hit_index are registered.
- State IDLE:
  - Pix_ready=1.
  - Pix_valid=1 → next state ISSUE; idx←0, best_hit←0, best_dist←all-ones, best_idx←0.
- State ISSUE: Read_index=idx. One cycle only (covers the sphere register's read latency), then → WAIT.
- State WAIT:
  - Hold Read_index.
  - Stay in WAIT until Isect_valid=1. There is no timeout.
  - On Isect_valid, if Isect_hit=1 and Isect_dist < best_dist (unsigned, strict): best_hit←1, best_dist←Isect_dist, best_idx←idx.
  - Then, if idx==N_SPHERES-1: → DONE and load the Res_* registers from the best_* registers. Otherwise: idx←idx+1 → ISSUE.
- State DONE:
  - Res_valid=1; Res_* held stable until the handshake completes.
  - Res_valid && Res_ready → IDLE, Res_valid←0.
  - In the same cycle, Hit←best_hit for exactly one cycle and Hit_index←best_idx.
- Isect_valid outside WAIT is ignored. Pix_valid outside IDLE is ignored; Pix_ready=0 outside IDLE.
- Tie rule: equal distances keep the earlier (lower) index.
- A hit with Isect_dist = all-ones never wins; it is reported as no hit.
- Timing with Isect_valid asserted in the first WAIT cycle:
  - Pixel accepted at cycle t.
  - ISSUE for index k at cycle t+1+2k.
  - Res_valid=1 at cycle t+1+2·N_SPHERES (cycle t+9 for N=4).
- Minimum throughput: one pixel per 2·N_SPHERES+2 cycles when Res_ready is held at 1.
- Res_ready=0 in DONE stalls the controller indefinitely, with outputs stable.

Decomposition:
- Shared package holds:
  - typedef fixed_real (64-bit, 32.32).
  - typedef sphere_idx_t.
  - constant DIST_MAX (all-ones).
  - state enum {IDLE, ISSUE, WAIT, DONE}.
- One natural sub-module, nearest_hit_tracker: holds the best_* registers and does the compare/update on Isect_valid. It has clear and load strobes from the FSM.
- The FSM and handshake live in sphere_scan_ctrl.

Test Plan:
- After Reset, check: Pix_ready=1, Res_valid=0, Hit=0, Read_index=0. Then Pix_valid, with a zero-latency responder returning no hits → Read_index sequence 0,1,2,3; Res_valid at t+9; Res_hit=0, Res_dist=all-ones; no Hit pulse.
- Distances (index 0..3, all hits): 0x0000_0A00_0000_0000, 0x0000_0500_0000_0000, 0x0000_0800_0000_0000, 0x0000_0500_0000_0000 → Res_index=1 (tie keeps lower index), Res_dist=0x0000_0500_0000_0000. Hit pulses one cycle with Hit_index=1 on handoff.
- Only sphere 3 hits, with dist=0x1 → Res_hit=1, Res_index=3, Res_dist=1.
- Responder latency of 5 cycles per sphere, plus spurious Isect_valid pulses during ISSUE → pulses are ignored; Read_index is held through each WAIT; Res_valid at t+1+4·6.
- Res_ready held 0 for 10 cycles in DONE → Res_* stable, Pix_ready=0, Hit=0. On Res_ready=1 → Hit pulse, then IDLE next cycle. Pix_valid held high back-to-back → the next scan starts immediately.
- Reset asserted while in WAIT on idx=2 → outputs return to reset values asynchronously; no Res_valid or Hit for the aborted pixel; the next pixel scans from index 0.
